// File: rtl/lockstep_compare.sv
// lockstep_compare: compares skew-aligned reference outputs against a unit under test and latches the first mismatch.
module lockstep_compare #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 2,
  parameter int SKEW = 0,
  parameter int STOP_ON_FAIL = 1,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   ref_data,
  input  logic [CHANNELS*WIDTH-1:0]   uut_data,
  input  logic [CHANNELS-1:0]         chan_en,
  output logic                        armed,
  output logic                        fail,
  output logic [CW-1:0]               fail_chan,
  output logic [WIDTH-1:0]            fail_ref,
  output logic [WIDTH-1:0]            fail_uut,
  output logic [31:0]                 fail_cycle,
  output logic [15:0]                 mismatch_count
);
  typedef enum logic [1:0] {SETTLE, ARMED, FAILED} state_t;
  state_t state, state_n;
  logic [CHANNELS*WIDTH-1:0] ref_d;
  logic [2:0] settle_cnt;
  logic [31:0] cyc_cnt;
  logic mis;
  logic [CW-1:0] mis_chan;
  logic [WIDTH-1:0] mis_ref, mis_uut;
  // The delay line is never reset; SETTLE waits for it to refill with post-reset data.
  generate
    if (SKEW == 0) begin : g_nodl
      assign ref_d = ref_data;
    end else begin : g_dl
      logic [CHANNELS*WIDTH-1:0] dl [SKEW];
      always_ff @(posedge clk) begin
        dl[0] <= ref_data;
        for (int i = 1; i < SKEW; i++) dl[i] <= dl[i-1];
      end
      assign ref_d = dl[SKEW-1];
    end
  endgenerate
  // Scan from the top so the lowest enabled mismatching channel wins.
  always_comb begin
    mis = 1'b0;
    mis_chan = '0;
    mis_ref = '0;
    mis_uut = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (chan_en[k] && ref_d[k*WIDTH +: WIDTH] != uut_data[k*WIDTH +: WIDTH]) begin
        mis = 1'b1;
        mis_chan = CW'(k);
        mis_ref = ref_d[k*WIDTH +: WIDTH];
        mis_uut = uut_data[k*WIDTH +: WIDTH];
      end
  end
  always_comb begin
    state_n = state;
    if (state == SETTLE && settle_cnt == 3'(SKEW)) state_n = ARMED;
    if (state == ARMED && mis && STOP_ON_FAIL != 0) state_n = FAILED;
  end
  always_ff @(posedge clk)
    state <= reset ? SETTLE : state_n;
  assign armed = state == ARMED;
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= '0;
      cyc_cnt <= '0;
      fail <= 1'b0;
      fail_chan <= '0;
      fail_ref <= '0;
      fail_uut <= '0;
      fail_cycle <= '0;
      mismatch_count <= '0;
    end else begin
      if (state == SETTLE) settle_cnt <= settle_cnt + 3'd1;
      if (state == ARMED) begin
        if (cyc_cnt != 32'hFFFF_FFFF) cyc_cnt <= cyc_cnt + 32'd1;
        if (mis) begin
          if (mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
          if (!fail) begin
            fail <= 1'b1;
            fail_chan <= mis_chan;
            fail_ref <= mis_ref;
            fail_uut <= mis_uut;
            fail_cycle <= cyc_cnt;
          end
        end
      end
    end
  end
endmodule

// File: doc/lockstep_compare.md
LOCKSTEP_COMPARE -- requirements
Module: lockstep_compare

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one compared channel.
REQ-002 Parameter CHANNELS, default 2: number of independent compared channels, range 1..16.
REQ-003 Parameter SKEW, default 0: reference-path delay in cycles, range 0..7; aligns a reference model that runs ahead of the DUT.
REQ-004 Parameter STOP_ON_FAIL, default 1: 1 = freeze on first mismatch; 0 = keep counting after a fail.
REQ-005 Local CW = max(1, clog2(CHANNELS)).
REQ-006 Interface is decided: reset is synchronous and active-high; the clock is clk.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 ref_data  input  CHANNELS*WIDTH  reference outputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 uut_data  input  CHANNELS*WIDTH  unit-under-test outputs, same packing as ref_data.
REQ-011 chan_en  input  CHANNELS  per-channel compare enable; a 0 bit masks that channel.
REQ-012 armed  output  1  high while comparison is active.
REQ-013 fail  output  1  sticky mismatch flag.
REQ-014 fail_chan  output  CW  lowest-index mismatching channel of the first failure.
REQ-015 fail_ref  output  WIDTH  delayed reference value of fail_chan at the first failure.
REQ-016 fail_uut  output  WIDTH  uut value of fail_chan at the first failure.
REQ-017 fail_cycle  output  32  armed-cycle index of the first failure.
REQ-018 mismatch_count  output  16  number of armed cycles with at least one mismatch.

Function
REQ-019 Delay line: ref_d SHALL be ref_data delayed by exactly SKEW register stages; for SKEW=0, ref_d = ref_data with no stage.
REQ-020 Delay line SHALL shift every cycle, including while reset is high and in every state.
REQ-021 States: SETTLE, ARMED, FAILED.
REQ-022 SETTLE: settle_cnt increments each non-reset cycle; when settle_cnt == SKEW, next state is ARMED; remains in SETTLE otherwise.
REQ-023 ARMED: mismatch in a cycle (mis) = OR over k of chan_en[k] AND (ref_d[k] != uut_data[k]).
REQ-024 ARMED, mis=1 and fail=0: next cycle fail=1 and capture fail_chan, fail_ref, fail_uut and fail_cycle from that sample.
REQ-025 ARMED, mis=1: go to FAILED if STOP_ON_FAIL=1; otherwise stay ARMED.
REQ-026 Capture fields SHALL never update after fail=1, except on reset.
REQ-027 fail_chan SHALL be the lowest-index enabled mismatching channel when several channels mismatch together.
REQ-028 mismatch_count SHALL increment by 1 per armed cycle with mis=1, regardless of how many channels mismatch, and saturate at 16'hFFFF.
REQ-029 cyc_cnt SHALL be 0 on the first ARMED cycle and increment each ARMED cycle, saturating at 32'hFFFFFFFF.
REQ-030 fail_cycle SHALL equal the cyc_cnt of the mismatching sample.
REQ-031 FAILED is terminal until reset: armed=0, and all counters and capture fields hold.
REQ-032 armed SHALL be 1 exactly in ARMED; comparisons SHALL occur nowhere else, including never in SETTLE.
REQ-033 Result latency: a mismatch sampled on edge N SHALL be visible on fail and mismatch_count after edge N.

Reset
REQ-034 On any cycle with reset=1: state <= SETTLE, settle_cnt <= 0, cyc_cnt <= 0.
REQ-035 On any cycle with reset=1, all outputs SHALL be 0: armed, fail, fail_chan, fail_ref, fail_uut, fail_cycle, mismatch_count.
REQ-036 Reset mid-operation, from any state including FAILED, SHALL fully re-enter SETTLE and re-arm after SKEW+1 non-reset cycles.
REQ-037 Delay-line contents SHALL NOT be cleared by reset, which is why SETTLE exists.

Verification
(WIDTH=8, CHANNELS=2, SKEW=2, STOP_ON_FAIL=1 unless stated.)
REQ-038 Scenario 1: reset 1 cycle, then uut = ref delayed 2, chan_en=2'b11 -> armed rises on the 3rd cycle after reset; fail=0 for 1000 cycles.
REQ-039 Scenario 2: after arm, at cyc_cnt=5 ch1 uut=8'h3C vs ref_d=8'h3D -> fail=1, fail_chan=1, fail_ref=8'h3D, fail_uut=8'h3C, fail_cycle=5, mismatch_count=1, armed=0.
REQ-040 Scenario 3: both channels mismatch in the same cycle -> fail_chan=0.
REQ-041 Scenario 4: chan_en=2'b01 and ch1 mismatches -> fail stays 0.
REQ-042 Scenario 5: STOP_ON_FAIL=0, mismatches at cyc_cnt 3, 4 and 9 -> fail_cycle=3, mismatch_count=3, armed stays 1.
REQ-043 Scenario 6: reset asserted while in FAILED -> all outputs 0 the next cycle, re-armed after 3 cycles, mismatch_count restarts from 0.
